// File: rtl/tone_player.sv
// rtl/tone_player.sv - command-driven square-wave note player for a buzzer pin
// Optional post-note articulation gap is compiled in by defining TONE_PLAYER_GAP_EN.
module tone_player #(
  parameter int unsigned CLK_HZ  = 12_000_000,
  parameter int unsigned BEAT_HZ = 8,
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned DUR_W   = 8,
  parameter int unsigned GAP_CYC = 12000
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             enable,
  input  logic             note_valid,
  output logic             note_ready,
  input  logic [4:0]       note_tone,
  input  logic [DUR_W-1:0] note_dur,
  output logic             busy,
  output logic             piano_out
);

  localparam int unsigned TICK_CYC = CLK_HZ / BEAT_HZ;
  localparam int unsigned TICK_W   = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYC - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
`ifdef TONE_PLAYER_GAP_EN
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
`endif

  // Half-period in clocks for tone codes 1..21; every other code is a rest.
  function automatic logic [DIV_W-1:0] half_calc(input int code);
    longint f10;
    if (code < 1 || code > 21) return '0;
    case ((code - 1) % 7)
      0:       f10 = 64'd2616;
      1:       f10 = 64'd2937;
      2:       f10 = 64'd3296;
      3:       f10 = 64'd3492;
      4:       f10 = 64'd3920;
      5:       f10 = 64'd4400;
      default: f10 = 64'd4939;
    endcase
    f10 = f10 << ((code - 1) / 7);
    return DIV_W'((longint'(CLK_HZ) * 64'd10) / (64'd2 * f10) - 64'd1);
  endfunction

  logic [DIV_W-1:0] half_tab [32];
  for (genvar g = 0; g < 32; g++) begin : g_half
    assign half_tab[g] = half_calc(g);
  end

  logic [1:0]        state_q, state_d;
  logic [4:0]        tone_q, tone_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [TICK_W-1:0] pre_q, pre_d;
  logic              piano_q, piano_d;
  logic              ready_q, ready_d;
`ifdef TONE_PLAYER_GAP_EN
  logic [GAP_W-1:0]  gap_q, gap_d;
`endif

  logic             accept;
  logic             tone_is_note;
  logic [DIV_W-1:0] half_cur;
  logic             tick_wrap;
  logic             play_end;

  assign note_ready   = ready_q & enable;
  assign accept       = note_valid & note_ready;
  assign busy         = (state_q != S_IDLE);
  assign piano_out    = piano_q;
  assign tone_is_note = (tone_q != 5'd0) && (tone_q <= 5'd21);
  assign half_cur     = half_tab[tone_q];
  assign tick_wrap    = (pre_q == TICK_LAST);
  assign play_end     = tick_wrap && (dur_q == DUR_W'(1));

  always_comb begin
    state_d = state_q;
    tone_d  = tone_q;
    dur_d   = dur_q;
    div_d   = div_q;
    pre_d   = pre_q;
    piano_d = piano_q;
`ifdef TONE_PLAYER_GAP_EN
    gap_d   = gap_q;
`endif
    if (!enable) begin
      state_d = S_IDLE;
      tone_d  = '0;
      dur_d   = '0;
      div_d   = '0;
      pre_d   = '0;
      piano_d = 1'b0;
`ifdef TONE_PLAYER_GAP_EN
      gap_d   = '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            tone_d = note_tone;
            dur_d  = note_dur;
            div_d  = '0;
            pre_d  = '0;
            // A zero-length note is swallowed without leaving IDLE.
            if (note_dur != '0) state_d = S_PLAY;
          end
        end
        S_PLAY: begin
          if (play_end) begin
            // End of note beats a coincident divider toggle.
            piano_d = 1'b0;
            div_d   = '0;
            pre_d   = '0;
            dur_d   = '0;
`ifdef TONE_PLAYER_GAP_EN
            state_d = S_GAP;
            gap_d   = '0;
`else
            state_d = S_IDLE;
`endif
          end else begin
            if (tick_wrap) begin
              pre_d = '0;
              dur_d = dur_q - DUR_W'(1);
            end else begin
              pre_d = pre_q + TICK_W'(1);
            end
            if (tone_is_note) begin
              if (div_q == half_cur) begin
                div_d   = '0;
                piano_d = ~piano_q;
              end else begin
                div_d = div_q + DIV_W'(1);
              end
            end else begin
              div_d   = '0;
              piano_d = 1'b0;
            end
          end
        end
`ifdef TONE_PLAYER_GAP_EN
        S_GAP: begin
          piano_d = 1'b0;
          if (gap_q == GAP_LAST) begin
            state_d = S_IDLE;
            gap_d   = '0;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
    ready_d = enable && (state_d == S_IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_IDLE;
      tone_q  <= '0;
      dur_q   <= '0;
      div_q   <= '0;
      pre_q   <= '0;
      piano_q <= 1'b0;
      ready_q <= 1'b0;
`ifdef TONE_PLAYER_GAP_EN
      gap_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      tone_q  <= tone_d;
      dur_q   <= dur_d;
      div_q   <= div_d;
      pre_q   <= pre_d;
      piano_q <= piano_d;
      ready_q <= ready_d;
`ifdef TONE_PLAYER_GAP_EN
      gap_q   <= gap_d;
`endif
    end
  end

endmodule

// File: tb/tb_tone_player.sv
// tb/tb_tone_player.sv - self-checking bench for tone_player (12 MHz clock, 1 kHz beat)
module tb_tone_player;
  localparam int TICK = 12000;
`ifdef TONE_PLAYER_GAP_EN
  localparam int GAP_LEN = 100;
`else
  localparam int GAP_LEN = 0;
`endif

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic       enable;
  logic       note_valid;
  logic [4:0] note_tone;
  logic [7:0] note_dur;
  logic       note_ready;
  logic       busy;
  logic       piano_out;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  bit cmp_on = 0;

  tone_player #(
    .CLK_HZ (12_000_000),
    .BEAT_HZ(1000),
    .DIV_W  (16),
    .DUR_W  (8),
    .GAP_CYC(100)
  ) dut (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .enable    (enable),
    .note_valid(note_valid),
    .note_ready(note_ready),
    .note_tone (note_tone),
    .note_dur  (note_dur),
    .busy      (busy),
    .piano_out (piano_out)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference half-period straight from the frequency table.
  function automatic int half_ref(input int code);
    int base;
    if (code < 1 || code > 21) return 0;
    case ((code - 1) % 7)
      0: base = 2616;
      1: base = 2937;
      2: base = 3296;
      3: base = 3492;
      4: base = 3920;
      5: base = 4400;
      default: base = 4939;
    endcase
    base = base * (1 << ((code - 1) / 7));
    return 120_000_000 / (2 * base) - 1;
  endfunction

  bit m_active = 0;
  bit m_ready  = 0;
  bit m_note   = 0;
  int m_age = 0, m_play = 0, m_total = 0, m_half = 0;

  // Note-level model: a note is an age counter against its play and total lengths.
  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      m_active <= 0;
      m_ready  <= 0;
      m_age    <= 0;
    end else if (!enable) begin
      m_active <= 0;
      m_ready  <= 0;
    end else if (m_active) begin
      m_age <= m_age + 1;
      if (m_age + 1 >= m_total) begin
        m_active <= 0;
        m_ready  <= 1;
      end
    end else if (note_valid && m_ready && note_dur != 8'd0) begin
      m_active <= 1;
      m_ready  <= 0;
      m_age    <= 0;
      m_note   <= (note_tone >= 5'd1 && note_tone <= 5'd21);
      m_half   <= half_ref(int'(note_tone));
      m_play   <= int'(note_dur) * TICK;
      m_total  <= int'(note_dur) * TICK + GAP_LEN;
    end else begin
      m_ready <= 1;
    end
  end

  function automatic int exp_piano();
    if (!m_active || !m_note || m_age >= m_play) return 0;
    return (m_age / (m_half + 1)) % 2;
  endfunction

  always @(negedge clk_in) begin
    #2;
    if (cmp_on) begin
      check_int("busy", int'(busy), int'(m_active));
      check_int("piano", int'(piano_out), exp_piano());
      check_int("ready", int'(note_ready), int'(m_ready && enable));
    end
  end

  function automatic logic sig_of(input int sel);
    case (sel)
      0: return busy;
      1: return piano_out;
      default: return note_ready;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input logic val, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_in);
      if (sig_of(sel) == val) begin
        at = cyc;
        break;
      end
    end
  endtask

  // Returns k = index of the accepting clock edge, -1 if never accepted.
  task automatic send(input logic [4:0] t, input logic [7:0] d, output int k);
    k = -1;
    note_tone  = t;
    note_dur   = d;
    note_valid = 1'b1;
    for (int i = 0; i < 40000; i++) begin
      if (note_ready) begin
        k = cyc + 1;
        break;
      end
      @(negedge clk_in);
    end
    @(negedge clk_in);
    note_valid = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, k2, r1, r2, f1, b;
    rst_n_in   = 1'b0;
    enable     = 1'b1;
    note_valid = 1'b0;
    note_tone  = 5'd0;
    note_dur   = 8'd0;
    @(posedge clk_in);
    cmp_on = 1;
    repeat (3) @(negedge clk_in);
    check_int("reset_busy", int'(busy), 0);
    check_int("reset_piano", int'(piano_out), 0);
    check_int("reset_ready", int'(note_ready), 0);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    check_int("ready_after_reset", int'(note_ready), 1);

    // M1 for three ticks
    send(5'd8, 8'd3, k);
    check_int("m1_accepted", int'(k >= 0), 1);
    wait_sig(1, 1'b1, 20000, r1);
    check_int("m1_first_rise", r1 - k, 11467);
    wait_sig(1, 1'b0, 20000, f1);
    check_int("m1_high_time", f1 - r1, 11467);
    wait_sig(1, 1'b1, 20000, r2);
    check_int("m1_period", r2 - r1, 22934);
    wait_sig(0, 1'b0, 40000, b);
    check_int("m1_busy_len", b - k, 36000 + GAP_LEN);
    check_int("m1_end_piano", int'(piano_out), 0);

`ifdef TONE_PLAYER_GAP_EN
    // Two back-to-back L1 notes separated by the articulation gap
    send(5'd1, 8'd1, k);
    send(5'd1, 8'd1, k2);
    check_int("gap_accept_spacing", k2 - k, 12101);
    wait_sig(0, 1'b0, 40000, b);
    check_int("gap_busy_len", b - k2, 12100);
`else
    // Rest codes 0 and 22 back to back
    send(5'd0, 8'd2, k);
    send(5'd22, 8'd1, k2);
    check_int("rest_accept_spacing", k2 - k, 24001);
    wait_sig(0, 1'b0, 40000, b);
    check_int("rest2_busy_len", b - k2, 12000);
`endif
    @(negedge clk_in);

    // H7 aborted by enable low mid-note
    send(5'd21, 8'd1, k);
    repeat (5000) @(negedge clk_in);
    check_int("h7_mid_piano", int'(piano_out), 1);
    enable = 1'b0;
    @(negedge clk_in);
    check_int("abort_piano", int'(piano_out), 0);
    check_int("abort_busy", int'(busy), 0);
    check_int("abort_ready", int'(note_ready), 0);
    repeat (3) @(negedge clk_in);
    enable = 1'b1;
    @(negedge clk_in);
    check_int("ready_after_enable", int'(note_ready), 1);

    // Zero-duration command is consumed in IDLE
    send(5'd5, 8'd0, k);
    check_int("dur0_accepted", int'(k >= 0), 1);
    check_int("dur0_busy", int'(busy), 0);
    check_int("dur0_ready", int'(note_ready), 1);
    repeat (20) @(negedge clk_in);
    check_int("dur0_piano", int'(piano_out), 0);

    repeat (4) @(negedge clk_in);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
